// File: rtl/key_entry_decoder_pkg.sv
// Shared types and key codes for the keypad entry path.
// Key codes 12-14 belong to the mode logic.
package key_entry_decoder_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ENTRY,
    CONVERT,
    DONE
  } state_t;

  localparam bcd_t KC_DIGIT_MAX = 4'd9;
  localparam bcd_t KC_CLEAR     = 4'd10;
  localparam bcd_t KC_BACK      = 4'd11;
  localparam bcd_t KC_MODE_A    = 4'd12;
  localparam bcd_t KC_MODE_B    = 4'd13;
  localparam bcd_t KC_MODE_C    = 4'd14;
  localparam bcd_t KC_ENTER     = 4'd15;

  function automatic logic is_digit(bcd_t c);
    return c <= KC_DIGIT_MAX;
  endfunction

  function automatic logic is_mode(bcd_t c);
    return (c == KC_MODE_A) ||
           (c == KC_MODE_B) ||
           (c == KC_MODE_C);
  endfunction

endpackage

// File: rtl/key_entry_decoder_if.sv
// Keypad-in / operand-out bundle for the entry decoder.
// master drives keys and watches the operand; slave is the decoder.
interface key_entry_decoder_if #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 32
);
  logic [3:0]              key_code;
  logic                    key_pressed;
  logic [4*MAX_DIGITS-1:0] bcd_digits;
  logic [3:0]              digit_count;
  logic                    full;
  logic                    busy;
  logic [VALUE_W-1:0]      value;
  logic                    value_valid;

  modport master (
    output key_code, key_pressed,
    input  bcd_digits, digit_count, full,
    input  busy, value, value_valid
  );

  modport slave (
    input  key_code, key_pressed,
    output bcd_digits, digit_count, full,
    output busy, value, value_valid
  );
endinterface

// File: rtl/key_entry_decoder_key_edge_detect.sv
// Turns a held key level into a single press event.
// The code is passed through so it lines up with the event.
module key_edge_detect
  import key_entry_decoder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  bcd_t key_code,
  input  logic key_pressed,
  output logic press,
  output bcd_t code
);

  logic prev_pressed;

  always_ff @(posedge clk) begin
    if (rst) prev_pressed <= 1'b0;
    else     prev_pressed <= key_pressed;
  end

  assign press = key_pressed & ~prev_pressed;
  assign code  = key_code;

endmodule

// File: rtl/key_entry_decoder.sv
// Collects typed decimal digits in BCD and converts them
// to binary, one digit per cycle, on ENTER.
module key_entry_decoder
  import key_entry_decoder_pkg::*;
#(
  parameter int   MAX_DIGITS = 4,
  parameter int   VALUE_W    = 32,
  parameter bcd_t KEY_CLEAR  = KC_CLEAR,
  parameter bcd_t KEY_BACK   = KC_BACK,
  parameter bcd_t KEY_ENTER  = KC_ENTER
) (
  input logic clk,
  input logic rst,
  key_entry_decoder_if.slave bus
);

  localparam int         DW      = 4 * MAX_DIGITS;
  localparam logic [3:0] MAX_CNT = 4'(MAX_DIGITS);

  state_t               state;
  state_t               state_nx;
  logic [DW-1:0]        digits;
  logic [3:0]           count;
  logic [3:0]           index;
  logic [VALUE_W-1:0]   acc;
  logic [VALUE_W-1:0]   acc_nx;
  logic [VALUE_W-1:0]   value;
  logic                 value_valid;
  logic                 press;
  bcd_t                 code;
  bcd_t                 cur_digit;
  logic                 key_ev;
  logic                 enter_ev;

  key_edge_detect u_edge (
    .clk         (clk),
    .rst         (rst),
    .key_code    (bus.key_code),
    .key_pressed (bus.key_pressed),
    .press       (press),
    .code        (code)
  );

  // Keys only act while entering; anything else is dropped.
  assign key_ev    = press && (state == ENTRY);
  assign enter_ev  = key_ev && (code == KEY_ENTER);
  assign cur_digit = bcd_t'(digits >> {index, 2'b00});
  assign acc_nx    = (acc << 3) + (acc << 1)
                   + VALUE_W'(cur_digit);

  always_ff @(posedge clk) begin
    if (rst) state <= ENTRY;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ENTRY:   if (enter_ev) state_nx = CONVERT;
      CONVERT: if (index == 4'd0) state_nx = DONE;
      DONE:    state_nx = ENTRY;
      default: state_nx = ENTRY;
    endcase
  end

  always_comb begin
    bus.busy        = (state == CONVERT);
    bus.full        = (count == MAX_CNT);
    bus.bcd_digits  = digits;
    bus.digit_count = count;
    bus.value       = value;
    bus.value_valid = value_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digits      <= '0;
      count       <= '0;
      index       <= '0;
      acc         <= '0;
      value       <= '0;
      value_valid <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      unique case (state)
        ENTRY: begin
          if (key_ev) begin
            unique case (1'b1)
              is_digit(code): begin
                if (count < MAX_CNT &&
                    !(code == 4'd0 && count == 4'd0)) begin
                  digits <= (digits << 4) | DW'(code);
                  count  <= count + 4'd1;
                end
              end
              code == KEY_BACK: begin
                if (count != 4'd0) begin
                  digits <= digits >> 4;
                  count  <= count - 4'd1;
                end
              end
              code == KEY_CLEAR: begin
                digits <= '0;
                count  <= '0;
              end
              code == KEY_ENTER: begin
                acc   <= '0;
                index <= (count == 4'd0) ? 4'd0
                                         : count - 4'd1;
              end
              is_mode(code): ;
              default: ;
            endcase
          end
        end
        CONVERT: begin
          acc   <= acc_nx;
          index <= index - 4'd1;
        end
        DONE: begin
          value       <= acc;
          value_valid <= 1'b1;
          digits      <= '0;
          count       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_entry_decoder.sv
// Directed bench for key_entry_decoder with a strobe scoreboard.
// Expected operands and strobe cycles are queued at ENTER.
module tb_key_entry_decoder;
  import key_entry_decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_entry_decoder_if #(.MAX_DIGITS(4), .VALUE_W(32)) bus ();

  key_entry_decoder #(.MAX_DIGITS(4), .VALUE_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] v;
    int          at;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] last_val = '0;
  logic        rst_d    = 1'b1;

  // Strobe monitor: every value_valid must match a queued entry.
  always @(negedge clk) begin
    if (bus.value_valid === 1'b1) begin : pop
      exp_t e;
      chk("strobe_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("value", bus.value, e.v);
        chk("strobe_cycle", cyc, e.at);
      end
    end else if (!rst && !rst_d) begin
      chk("value_hold", bus.value, last_val);
    end
    last_val = bus.value;
    rst_d    = rst;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input int hold);
    bus.key_code    = k;
    bus.key_pressed = 1'b1;
    step(hold);
    bus.key_pressed = 1'b0;
    step(1);
  endtask

  task automatic enter(input logic [31:0] want,
                       input int n,
                       input int intr);
    int len;
    len = (n > 0) ? n : 1;
    sb.push_back('{want, cyc + len + 2});
    bus.key_code    = KC_ENTER;
    bus.key_pressed = 1'b1;
    step(1);
    bus.key_pressed = 1'b0;
    for (int i = 1; i <= len + 1; i++) begin
      if (i <= len) begin
        chk("busy_convert", bus.busy, 1);
        chk("count_stable", bus.digit_count, 64'(n));
      end else begin
        chk("busy_done", bus.busy, 0);
      end
      if (intr >= 0 && i == 2) begin
        bus.key_code    = 4'(intr);
        bus.key_pressed = 1'b1;
      end
      if (intr >= 0 && i == 3) bus.key_pressed = 1'b0;
      step(1);
    end
    chk("busy_after", bus.busy, 0);
    chk("count_cleared", bus.digit_count, 0);
    chk("digits_cleared", bus.bcd_digits, 0);
    step(1);
  endtask

  initial begin
    bus.key_code    = 4'd0;
    bus.key_pressed = 1'b0;
    rst = 1'b1;
    step(2);
    chk("rst_digits", bus.bcd_digits, 0);
    chk("rst_count", bus.digit_count, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_value", bus.value, 0);
    chk("rst_valid", bus.value_valid, 0);
    rst = 1'b0;
    step(1);

    press(4'd1, 3);
    press(4'd2, 3);
    press(4'd3, 3);
    chk("t1_digits", bus.bcd_digits, 64'h0123);
    chk("t1_count", bus.digit_count, 3);
    enter(32'd123, 3, -1);

    press(4'd9, 2);
    press(4'd8, 2);
    press(4'd7, 2);
    press(4'd6, 2);
    chk("t2_full", bus.full, 1);
    press(4'd5, 2);
    chk("t2_digits", bus.bcd_digits, 64'h9876);
    chk("t2_count", bus.digit_count, 4);
    enter(32'd9876, 4, -1);
    chk("t2_full_after", bus.full, 0);

    press(KC_BACK, 2);
    chk("back_empty_count", bus.digit_count, 0);
    chk("back_empty_digits", bus.bcd_digits, 0);
    press(4'd4, 2);
    press(4'd5, 2);
    press(KC_BACK, 2);
    chk("back_digits", bus.bcd_digits, 64'h0004);
    press(4'd7, 2);
    chk("t3_digits", bus.bcd_digits, 64'h0047);
    enter(32'd47, 2, -1);

    press(4'd0, 2);
    chk("lead_zero_count", bus.digit_count, 0);
    press(4'd0, 2);
    press(4'd3, 2);
    chk("t4_digits", bus.bcd_digits, 64'h0003);
    chk("t4_count", bus.digit_count, 1);
    press(KC_MODE_B, 2);
    chk("mode_ignored", bus.bcd_digits, 64'h0003);
    press(KC_CLEAR, 2);
    chk("clear_count", bus.digit_count, 0);
    chk("clear_digits", bus.bcd_digits, 0);
    chk("clear_value", bus.value, 32'd47);
    enter(32'd0, 0, -1);

    press(4'd2, 20);
    chk("held_count", bus.digit_count, 1);
    chk("held_digits", bus.bcd_digits, 64'h0002);
    press(4'd8, 3);
    enter(32'd28, 2, 5);
    chk("drop_count", bus.digit_count, 0);

    press(4'd5, 2);
    press(4'd6, 2);
    chk("t6_digits", bus.bcd_digits, 64'h0056);
    bus.key_code    = KC_ENTER;
    bus.key_pressed = 1'b1;
    step(1);
    bus.key_pressed = 1'b0;
    chk("t6_busy1", bus.busy, 1);
    step(1);
    chk("t6_busy2", bus.busy, 1);
    rst = 1'b1;
    step(1);
    chk("t6_digits_rst", bus.bcd_digits, 0);
    chk("t6_count_rst", bus.digit_count, 0);
    chk("t6_full_rst", bus.full, 0);
    chk("t6_busy_rst", bus.busy, 0);
    chk("t6_value_rst", bus.value, 0);
    chk("t6_valid_rst", bus.value_valid, 0);
    rst = 1'b0;
    step(8);
    chk("t6_value_after", bus.value, 0);
    chk("t6_busy_after", bus.busy, 0);

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_entry_decoder.md
Name: key_entry_decoder

Overview:
- Reverse of the binary-to-digit display path: takes debounced key codes from the keypad scanner and turns a typed decimal number into a binary operand.
- Holds the typed digits in BCD so the operand displays can show them while they are being entered.
- On ENTER, converts the digits to binary with a multi-cycle Horner loop (one digit per cycle) and presents the result with a one-cycle valid strobe.
- Feeds the calculator operand registers.

Parameters:
- MAX_DIGITS, 4, number of decimal digits held (1..9).
- VALUE_W, 32, width of the binary result.
- KEY_CLEAR, 10, key code that clears the entry.
- KEY_BACK, 11, key code that deletes the least significant digit.
- KEY_ENTER, 15, key code that starts conversion.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_code  in  4  current key code from the keypad scanner; valid while key_pressed=1.
- key_pressed  in  1  level; high while a key is held.
- bcd_digits  out  4*MAX_DIGITS  typed digits, digit 0 (LSD) in bits [3:0].
- digit_count  out  4  number of digits currently typed.
- full  out  1  high when digit_count==MAX_DIGITS.
- busy  out  1  high while in CONVERT.
- value  out  VALUE_W  last converted number; held between conversions.
- value_valid  out  1  one-cycle strobe when value updates.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: bcd_digits=0, digit_count=0, full=0, busy=0, value=0, value_valid=0, accumulator=0, prev_pressed=0, state=ENTRY.
- Reset mid-CONVERT aborts the conversion; no strobe is produced.
- Key event:
  - prev_pressed is a register of key_pressed.
  - event = key_pressed & ~prev_pressed, decoded from key_code in the same cycle.
  - A held key yields exactly one event.
  - Events arriving in CONVERT or DONE are dropped and are not queued.
- States: ENTRY, CONVERT, DONE.
- ENTRY, digit key (0-9):
  - If digit_count<MAX_DIGITS: shift digits up one position, insert the new digit at position 0, digit_count+1.
  - If full: ignored.
  - Key 0 with digit_count==0: ignored (no leading zeros).
- ENTRY, KEY_BACK:
  - If digit_count>0: shift digits down one position, top digit becomes 0, digit_count-1.
  - If digit_count==0: no-op.
- ENTRY, KEY_CLEAR: digits=0, digit_count=0. value is unchanged.
- ENTRY, KEY_ENTER:
  - Load accumulator=0 and index=digit_count-1.
  - Go to CONVERT; busy=1 from the next cycle.
- ENTRY, codes 12-14 and any unassigned code: ignored (owned by the mode logic).
- CONVERT, each cycle:
  - accumulator = accumulator*10 + digit[index], where *10 is (acc<<3)+(acc<<1), truncated to VALUE_W.
  - index decrements; after index 0 is processed, go to DONE.
  - With digit_count==0, spend one cycle with accumulator=0.
  - Cycles spent in CONVERT = max(digit_count,1).
- DONE, one cycle:
  - value=accumulator and value_valid=1 (both registered, visible in the cycle after DONE).
  - Digits cleared, digit_count=0, busy=0, return to ENTRY.
- Latency: with the ENTER event in cycle E, value_valid is high in cycle E+max(n,1)+2 only, where n is the digit count.
- full is combinational from digit_count. bcd_digits and digit_count are stable during CONVERT.
- value never changes except on the value_valid strobe.

Decomposition:
- Shared package: key code constants (digits 0-9, KEY_CLEAR, KEY_BACK, KEY_ENTER, mode codes 12-14), state enum {ENTRY, CONVERT, DONE}, BCD digit typedef (4 bits).
- One natural sub-module: key_edge_detect (registered prev plus rising-edge event output with code capture), reusable by the mode logic.

Test Plan:
- Reset, then press 1,2,3 (each held 3 cycles), then ENTER -> bcd_digits=0x0123, digit_count=3 before ENTER; busy for 3 cycles; value=123 with a single value_valid pulse at E+5; digit_count back to 0.
- Press 9,8,7,6,5 with MAX_DIGITS=4 -> 5 ignored, full=1, ENTER gives value=9876.
- Press 4,5,BACK,7,ENTER -> digits 0x0047 before ENTER, value=47. BACK with 0 digits -> no change.
- Press 0,0,3, then KEY_CLEAR, then ENTER -> leading zeros dropped (digits 0x0003 before CLEAR); after CLEAR digit_count=0; ENTER gives value=0 and value_valid at E+3.
- Key held 20 cycles -> one digit inserted. A digit pressed during CONVERT -> dropped, no effect on the result.
- rst asserted in the second CONVERT cycle of "56" + ENTER -> all outputs at reset values next cycle, no value_valid, prior value replaced by 0.
